// File: rtl/simple_cpu_arb_pkg.sv
// Shared types and helpers for the simpleCpu AXI4-Lite requester arbiter.
package simple_cpu_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The slave decodes 32-bit registers only, so byte lanes are cleared.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/simple_cpu_rr_arbiter.sv
// Round-robin grant generator; the pointer names the highest-priority requester
// and moves to the slot after the winner whenever advance_i is pulsed.
module simple_cpu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDX_W'(cand);
            end
        end
    end

    assign ptr_d = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/simple_cpu_axil_arbiter.sv
// Shares the simpleCpu AXI4-Lite slave port among NUM_REQ requesters, one transaction at a time.
// Optional watchdog: define SIMPLECPU_ARB_TIMEOUT_EN to abort stalled transactions with DECERR.
module simple_cpu_axil_arbiter
    import simple_cpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    accept;
    logic                    abort;
    logic                    timeout;
    logic                    aw_hs, w_hs;

    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    aw_done_q, w_done_q;

    simple_cpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk         (ACLK),
        .rst         (ARESET),
        .req_i       (req_valid),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign accept    = (state_q == ST_IDLE) && (|grant);
    assign req_ready = accept ? grant : '0;
    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;

`ifdef SIMPLECPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_q;
    logic             waiting;

    assign waiting = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
    assign timeout = waiting && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET || !waiting || (state_d != state_q)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE:    if (accept) state_d = req_we[grant_idx] ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            ST_WR_RESP: if (M_AXI_BVALID) state_d = ST_DONE;
            ST_RD_REQ:  if (M_AXI_ARREADY) state_d = ST_RD_RESP;
            ST_RD_RESP: if (M_AXI_RVALID) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A handshake landing on the watchdog's last cycle still wins.
        if (timeout && (state_d == state_q)) begin
            abort   = 1'b1;
            state_d = ST_DONE;
        end
    end

    always_comb begin
        M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
        M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
        M_AXI_BREADY  = (state_q == ST_WR_RESP);
        M_AXI_ARVALID = (state_q == ST_RD_REQ);
        M_AXI_RREADY  = (state_q == ST_RD_RESP);
        rsp_valid     = '0;
        if (state_q == ST_DONE) rsp_valid[idx_q] = 1'b1;
    end

    assign M_AXI_AWADDR = ADDR_WIDTH'(word_align(32'(addr_q)));
    assign M_AXI_ARADDR = ADDR_WIDTH'(word_align(32'(addr_q)));
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                idx_q     <= grant_idx;
                addr_q    <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q   <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q   <= req_wstrb[grant_idx*4 +: 4];
                rdata_q   <= '0;
                resp_q    <= RESP_OKAY;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if ((state_q == ST_WR_RESP) && M_AXI_BVALID) resp_q <= M_AXI_BRESP;
            if ((state_q == ST_RD_RESP) && M_AXI_RVALID) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
            if (abort) begin
                rdata_q <= '0;
                resp_q  <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_simple_cpu_axil_arbiter.sv
// Directed bench for simple_cpu_axil_arbiter with a small behavioural AXI4-Lite register slave.
module tb_simple_cpu_axil_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR*4-1:0]   req_wstrb = '0;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [AW-1:0]     M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0]     M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID, M_AXI_BREADY;
    logic [AW-1:0]     M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0]     M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID, M_AXI_RREADY;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    simple_cpu_axil_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Behavioural slave: 4 registers, configurable AWREADY delay, ARREADY and RVALID gates.
    logic [31:0] mem [4];
    int          aw_delay = 0;
    int          aw_wcnt;
    logic        ar_en = 1'b1;
    logic        r_en = 1'b1;
    logic        aw_hs, w_hs, ar_hs;
    logic        aw_got, w_got, bvalid, r_pend;
    logic [3:0]  aw_addr_l, wstrb_l, ws;
    logic [31:0] wdata_l, wd, r_data;
    logic [1:0]  wa;

    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs         = M_AXI_ARVALID && M_AXI_ARREADY;
    assign M_AXI_AWREADY = (aw_delay == 0) || (aw_wcnt >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = ar_en;
    assign M_AXI_BVALID  = bvalid;
    assign M_AXI_BRESP   = 2'b00;
    assign M_AXI_RVALID  = r_pend && r_en;
    assign M_AXI_RDATA   = r_data;
    assign M_AXI_RRESP   = 2'b00;
    assign wa = aw_hs ? M_AXI_AWADDR[3:2] : aw_addr_l[3:2];
    assign wd = w_hs ? M_AXI_WDATA : wdata_l;
    assign ws = w_hs ? M_AXI_WSTRB : wstrb_l;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_wcnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wcnt <= aw_wcnt + 1;
            else if (aw_hs) aw_wcnt <= 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= M_AXI_AWADDR; end
            if (w_hs) begin w_got <= 1'b1; wdata_l <= M_AXI_WDATA; wstrb_l <= M_AXI_WSTRB; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                for (int b = 0; b < 4; b++) if (ws[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
                bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && M_AXI_BREADY) bvalid <= 1'b0;
            if (ar_hs) begin r_pend <= 1'b1; r_data <= mem[M_AXI_ARADDR[3:2]]; end
            else if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 1'b0;
        end
    end

    // Channel monitor
    logic        mon_clr = 1'b1;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_seen, w_seen, bready_early;
    logic [3:0]  last_awaddr, last_araddr, last_wstrb;
    logic [2:0]  last_awprot, last_arprot;
    logic [31:0] last_wdata;

    always @(posedge ACLK) begin
        if (mon_clr) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; bready_early <= 1'b0;
        end else begin
            if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_AXI_WVALID)  w_cnt  <= w_cnt + 1;
            if (M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
            if (M_AXI_BREADY && !(aw_seen && w_seen)) bready_early <= 1'b1;
            if (aw_hs) begin aw_seen <= 1'b1; last_awaddr <= M_AXI_AWADDR; last_awprot <= M_AXI_AWPROT; end
            if (w_hs)  begin w_seen <= 1'b1; last_wdata <= M_AXI_WDATA; last_wstrb <= M_AXI_WSTRB; end
            if (ar_hs) begin last_araddr <= M_AXI_ARADDR; last_arprot <= M_AXI_ARPROT; end
        end
    end

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        cyc();
        mon_clr = 1'b0;
    endtask

    // Issues one request and waits for its response; lat = cycles from grant to rsp_valid, -1 on timeout.
    task automatic do_txn(input int r, input logic we, input logic [3:0] addr, input logic [31:0] wdat,
                          input logic [3:0] strb, output logic [31:0] rd, output logic [1:0] rs,
                          output int lat);
        int n;
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*AW +: AW] = addr;
        req_wdata[r*DW +: DW] = wdat;
        req_wstrb[r*4 +: 4] = strb;
        rd = '0; rs = '0; lat = -1; n = 0;
        #1;
        while (!req_ready[r] && n < 50) begin cyc(); #1; n++; end
        if (!req_ready[r]) begin req_valid[r] = 1'b0; return; end
        lat = 0;
        do begin
            cyc();
            lat++;
            if (lat == 1) req_valid[r] = 1'b0;
            #1;
        end while (!rsp_valid[r] && lat < 300);
        if (rsp_valid[r]) begin rd = rsp_rdata; rs = rsp_resp; end
        else lat = -1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) cyc();
        #1;
        checks++; if ({req_ready, rsp_valid} !== 4'b0) begin errors++; $display("FAIL reset_req_rsp: got %b expected 0", {req_ready, rsp_valid}); end
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_handshakes: got %b expected 0",
                               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        checks++; if ({rsp_rdata, rsp_resp} !== 34'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_rdata, rsp_resp}); end
        checks++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 44'h0) begin
            errors++; $display("FAIL reset_axi_payload: got %h expected 0", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}); end
        ARESET = 1'b0;
        mon_reset();
    endtask

    task automatic test_single_write();
        logic [31:0] rd; logic [1:0] rs; int lat;
        do_txn(0, 1'b1, 4'h4, 32'h2, 4'hF, rd, rs, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL wr_resp: got %b expected 00", rs); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
        checks++; if (last_awaddr !== 4'h4) begin errors++; $display("FAIL wr_awaddr: got %h expected 4", last_awaddr); end
        checks++; if (last_wdata !== 32'h2) begin errors++; $display("FAIL wr_wdata: got %h expected 2", last_wdata); end
        checks++; if (last_wstrb !== 4'hF) begin errors++; $display("FAIL wr_wstrb: got %h expected f", last_wstrb); end
        checks++; if (last_awprot !== 3'b000) begin errors++; $display("FAIL wr_awprot: got %b expected 000", last_awprot); end
        // Unaligned byte address from requester 1 with partial strobes
        do_txn(1, 1'b1, 4'hB, 32'h55, 4'h3, rd, rs, lat);
        checks++; if (last_awaddr !== 4'h8) begin errors++; $display("FAIL wr_align: got %h expected 8", last_awaddr); end
        checks++; if (last_wstrb !== 4'h3) begin errors++; $display("FAIL wr_wstrb_pass: got %h expected 3", last_wstrb); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr1_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_write_readback();
        logic [31:0] rd; logic [1:0] rs; int lat;
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b1, 4'(i*4), 32'(i+1), 4'hF, rd, rs, lat);
            checks++; if (rs !== 2'b00 || lat !== 3) begin errors++; $display("FAIL wb_write%0d: got resp %b lat %0d expected 00 3", i, rs, lat); end
        end
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b0, 4'(i*4), 32'h0, 4'h0, rd, rs, lat);
            checks++; if (rd !== 32'(i+1)) begin errors++; $display("FAIL wb_rdata%0d: got %h expected %h", i, rd, 32'(i+1)); end
            checks++; if (rs !== 2'b00 || lat !== 3) begin errors++; $display("FAIL wb_read%0d: got resp %b lat %0d expected 00 3", i, rs, lat); end
        end
        checks++; if ({last_araddr, last_arprot} !== 7'b1100_000) begin errors++; $display("FAIL rd_araddr_prot: got %b expected 1100000", {last_araddr, last_arprot}); end
    endtask

    task automatic test_back_to_back();
        int ng; int last; int gidx;
        ARESET = 1'b1;
        req_valid = 2'b11; req_we = 2'b00; req_addr = '0;
        cyc(); cyc();
        ARESET = 1'b0;
        ng = 0; last = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                gidx = req_ready[1] ? 1 : 0;
                checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready); end
                checks++; if (gidx !== ng % 2) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", ng, gidx, ng % 2); end
                if (ng > 0) begin
                    checks++; if (c - last !== 4) begin errors++; $display("FAIL rr_gap%0d: got %0d expected 4", ng, c - last); end
                end
                last = c;
                ng++;
            end
            cyc();
        end
        checks++; if (ng !== 4) begin errors++; $display("FAIL rr_grants: got %0d expected 4", ng); end
        req_valid = 2'b00;
        repeat (6) cyc();
    endtask

    task automatic test_aw_delay();
        logic [31:0] rd; logic [1:0] rs; int lat;
        aw_delay = 3;
        mon_reset();
        do_txn(0, 1'b1, 4'hC, 32'hA5, 4'hF, rd, rs, lat);
        aw_delay = 0;
        checks++; if (aw_cnt !== 4) begin errors++; $display("FAIL awd_awvalid_cycles: got %0d expected 4", aw_cnt); end
        checks++; if (w_cnt !== 1) begin errors++; $display("FAIL awd_wvalid_cycles: got %0d expected 1", w_cnt); end
        checks++; if (bready_early !== 1'b0) begin errors++; $display("FAIL awd_bready_early: got %b expected 0", bready_early); end
        checks++; if (lat !== 6 || rs !== 2'b00) begin errors++; $display("FAIL awd_latency_resp: got %0d/%b expected 6/00", lat, rs); end
    endtask

    task automatic test_reset_mid();
        int n; int g;
        r_en = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 4'h8;
        n = 0; #1;
        while (!req_ready[0] && n < 20) begin cyc(); #1; n++; end
        cyc();
        req_valid[0] = 1'b0;
        n = 0; #1;
        while (!M_AXI_RREADY && n < 10) begin cyc(); #1; n++; end
        checks++; if (M_AXI_RREADY !== 1'b1) begin errors++; $display("FAIL rm_reach_rd_resp: got %b expected 1", M_AXI_RREADY); end
        ARESET = 1'b1;
        cyc(); #1;
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid} !== 7'b0) begin
            errors++; $display("FAIL rm_outputs_dropped: got %b expected 0",
                               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}); end
        r_en = 1'b1;
        req_valid = 2'b11; req_we = 2'b00; req_addr = {4'h0, 4'h8};
        cyc();
        ARESET = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b expected 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        n = 0; #1;
        while (!rsp_valid[0] && n < 10) begin cyc(); #1; n++; end
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata !== 32'h3) begin
            errors++; $display("FAIL rm_post_read: got valid %b data %h expected 1 00000003", rsp_valid[0], rsp_rdata); end
        g = 0;
        for (int c = 0; c < 6; c++) begin cyc(); #1; if (req_ready != 2'b00) g++; end
        checks++; if (g !== 0) begin errors++; $display("FAIL rm_dropped_req: got %0d grants expected 0", g); end
    endtask

`ifdef SIMPLECPU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] rs; int lat;
        ar_en = 1'b0;
        mon_reset();
        do_txn(0, 1'b0, 4'h4, 32'h0, 4'h0, rd, rs, lat);
        ar_en = 1'b1;
        checks++; if (ar_cnt !== 16) begin errors++; $display("FAIL to_arvalid_cycles: got %0d expected 16", ar_cnt); end
        checks++; if (rs !== 2'b11 || rd !== 32'h0) begin errors++; $display("FAIL to_decerr: got %b/%h expected 11/0", rs, rd); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL to_latency: got %0d expected 17", lat); end
        do_txn(1, 1'b0, 4'h4, 32'h0, 4'h0, rd, rs, lat);
        checks++; if (rs !== 2'b00 || rd !== 32'h2 || lat !== 3) begin
            errors++; $display("FAIL to_recover: got %b/%h/%0d expected 00/2/3", rs, rd, lat); end
    endtask
`else
    task automatic test_no_timeout();
        int n; int hi; int seen;
        ar_en = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 4'h4;
        n = 0; #1;
        while (!req_ready[0] && n < 20) begin cyc(); #1; n++; end
        cyc();
        req_valid[0] = 1'b0;
        hi = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (M_AXI_ARVALID) hi++;
            if (rsp_valid != 2'b00) seen++;
            cyc();
        end
        checks++; if (hi !== 40 || seen !== 0) begin errors++; $display("FAIL nt_wait: got arvalid %0d rsp %0d expected 40 0", hi, seen); end
        ar_en = 1'b1;
        n = 0; #1;
        while (!rsp_valid[0] && n < 10) begin cyc(); #1; n++; end
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata !== 32'h2 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL nt_complete: got %b/%h/%b expected 1/2/00", rsp_valid[0], rsp_rdata, rsp_resp); end
        repeat (2) cyc();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_write_readback();
        test_back_to_back();
        test_aw_delay();
        test_reset_mid();
`ifdef SIMPLECPU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
